// File: rtl/tuner_if.sv
// Bundle of sample-input, control and shared-slice signals for tuner_sched.
// The master side is the sample source and slice owner; tuner_sched is the slave.
interface tuner_if #(
    parameter int dsz = 14,
    parameter int psz = 12,
    parameter int asz = 32
);
    logic                  in_valid;
    logic signed [dsz-1:0] in;
    logic [asz-1:0]        freq;
    logic                  freq_wr;
    logic                  phs_rst;
    logic                  ovr_clr;
    logic [psz-1:0]        slc_phs;
    logic                  slc_shf_90;
    logic signed [dsz-1:0] slc_in;
    logic signed [dsz-1:0] slc_out;
    logic signed [dsz-1:0] i_out;
    logic signed [dsz-1:0] q_out;
    logic                  out_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output in_valid, in, freq, freq_wr, phs_rst, ovr_clr, slc_out,
        input  slc_phs, slc_shf_90, slc_in, i_out, q_out, out_valid, busy, overrun
    );

    modport slave (
        input  in_valid, in, freq, freq_wr, phs_rst, ovr_clr, slc_out,
        output slc_phs, slc_shf_90, slc_in, i_out, q_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/tuner_sched.sv
// Time-shares one tuner slice between the I and Q legs of each real sample,
// tracking the phase accumulator and re-assembling slice results into I/Q pairs.
module tuner_sched #(
    parameter int dsz     = 14,
    parameter int psz     = 12,
    parameter int asz     = 32,
    parameter int LAT_PH  = 4,
    parameter int LAT_OUT = 2
) (
    input logic     clk,
    input logic     reset,
    tuner_if.slave  bus
);
    // The data pipe and the valid pipe share taps, so LAT_PH must be at least 2.
    localparam int DDEPTH = LAT_PH - 1;
    localparam int VDEPTH = LAT_PH + LAT_OUT;

    typedef enum logic [1:0] {
        IDLE,
        ISS_I,
        ISS_Q
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   drop;

    logic [asz-1:0]        acc;
    logic [asz-1:0]        freq_shadow;
    logic [asz-1:0]        phase;
    logic                  rst_pend;
    logic [psz-1:0]        phs_reg;
    logic signed [dsz-1:0] sample;
    logic                  overrun_reg;

    logic [VDEPTH-1:0]     vpipe;
    logic signed [dsz-1:0] dpipe [DDEPTH];
    logic signed [dsz-1:0] slc_in_reg;
    logic                  i_cap;
    logic                  q_cap;
    logic signed [dsz-1:0] i_reg;
    logic signed [dsz-1:0] q_reg;
    logic                  out_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ISS_I;
                end
            end
            ISS_I: begin
                drop       = bus.in_valid;
                state_next = ISS_Q;
            end
            ISS_Q: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ISS_I;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A clear request arriving with the accepted sample applies to that sample.
    assign phase = (bus.phs_rst || rst_pend) ? '0 : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            freq_shadow <= '0;
            rst_pend    <= 1'b0;
            phs_reg     <= '0;
            sample      <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (bus.freq_wr) freq_shadow <= bus.freq;
            if (accept) begin
                acc      <= phase + freq_shadow;
                phs_reg  <= phase[asz-1 -: psz];
                sample   <= bus.in;
                rst_pend <= 1'b0;
            end else if (bus.phs_rst) begin
                rst_pend <= 1'b1;
            end
            if (drop)             overrun_reg <= 1'b1;
            else if (bus.ovr_clr) overrun_reg <= 1'b0;
        end
    end

    // vpipe[j] and dpipe[j] both describe the sample issued j+1 cycles ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
            for (int k = 0; k < DDEPTH; k++) dpipe[k] <= '0;
        end else begin
            vpipe    <= {vpipe[VDEPTH-2:0], (state == ISS_I)};
            dpipe[0] <= sample;
            for (int k = 1; k < DDEPTH; k++) dpipe[k] <= dpipe[k-1];
        end
    end

    assign i_cap = vpipe[VDEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            slc_in_reg    <= '0;
            q_cap         <= 1'b0;
            i_reg         <= '0;
            q_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (vpipe[LAT_PH-2]) slc_in_reg <= dpipe[LAT_PH-2];
            q_cap         <= i_cap;
            out_valid_reg <= q_cap;
            if (i_cap) i_reg <= bus.slc_out;
            if (q_cap) q_reg <= bus.slc_out;
        end
    end

    assign bus.slc_phs    = phs_reg;
    assign bus.slc_shf_90 = (state == ISS_Q);
    assign bus.busy       = (state == ISS_I);
    assign bus.slc_in     = slc_in_reg;
    assign bus.i_out      = i_reg;
    assign bus.q_out      = q_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: doc/tuner_sched.md
TUNER_SCHED -- requirements
Module: tuner_sched

Interface
REQ-001 Parameter dsz, default 14, sample/result width.
REQ-002 Parameter psz, default 12, slice phase width.
REQ-003 Parameter asz, default 32, phase accumulator and frequency word width; asz SHALL be >= psz.
REQ-004 Parameter LAT_PH, default 4, cycles from slc_phs presented to slc_in sampled by slice.
REQ-005 Parameter LAT_OUT, default 2, cycles from slc_in sampled to slc_out valid.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 in_valid  in  1  one-cycle strobe, new real sample.
REQ-009 in  in  dsz signed  real sample, valid with in_valid.
REQ-010 freq  in  asz  phase increment.
REQ-011 freq_wr  in  1  load freq into shadow register.
REQ-012 phs_rst  in  1  request phase-accumulator clear at next accepted sample.
REQ-013 ovr_clr  in  1  clear sticky overrun.
REQ-014 slc_phs  out  psz  phase to shared tuner slice.
REQ-015 slc_shf_90  out  1  0 = I leg, 1 = Q leg.
REQ-016 slc_in  out  dsz signed  data to shared slice.
REQ-017 slc_out  in  dsz signed  slice result.
REQ-018 i_out, q_out  out  dsz signed each  complex result.
REQ-019 out_valid  out  1  one-cycle strobe, i_out/q_out valid.
REQ-020 busy  out  1  high in ISS_I.
REQ-021 overrun  out  1  sticky, sample dropped.

Function
REQ-022 FSM states IDLE, ISS_I, ISS_Q; IDLE/ISS_Q + in_valid -> ISS_I; ISS_Q without in_valid -> IDLE; ISS_I -> ISS_Q unconditionally.
REQ-023 Sample accepted only when in_valid in IDLE or ISS_Q; minimum accepted spacing 2 cycles.
REQ-024 in_valid in ISS_I: sample dropped, no FSM change, overrun set next cycle.
REQ-025 overrun cleared by ovr_clr; ovr_clr with simultaneous drop leaves overrun set.
REQ-026 On acceptance: sample latched, phase P = acc (or 0 if phs_rst pending), acc <= P + freq_shadow, pending phs_rst cleared.
REQ-027 phs_rst pulse sets pending flag; phs_rst coinciding with acceptance applies to that acceptance.
REQ-028 freq_wr loads freq_shadow; freq_wr coinciding with acceptance takes effect from the following acceptance.
REQ-029 acc addition modulo 2^asz, wrap silent.
REQ-030 ISS_I: slc_phs = P[asz-1:asz-psz], slc_shf_90 = 0; ISS_Q: same slc_phs, slc_shf_90 = 1; IDLE: slc_phs holds, slc_shf_90 = 0.
REQ-031 Latched sample driven on slc_in exactly LAT_PH cycles after ISS_I and held for the following cycle (Q leg); otherwise slc_in holds.
REQ-032 slc_out captured to i_out LAT_PH+LAT_OUT cycles after ISS_I, to q_out one cycle later; out_valid pulses in cycle after q_out capture, i_out/q_out held until next capture.
REQ-033 Issue-to-out_valid latency LAT_PH+LAT_OUT+2 cycles; back-to-back samples at spacing 2 give out_valid every 2 cycles, no loss.
REQ-034 Valid tracking via shift register; no FSM dependence on results.

Reset
REQ-035 Reset: FSM IDLE, acc 0, freq_shadow 0, phs_rst pending 0, overrun 0, all pipeline valid bits 0.
REQ-036 Reset: slc_phs, slc_shf_90, slc_in, i_out, q_out, out_valid, busy all 0.
REQ-037 Reset mid-operation discards in-flight samples; no out_valid until a new sample is accepted post-reset.

Verification
REQ-038 freq=0x40000000, freq_wr, then 5 samples spacing 4 -> slc_phs 0x000,0x400,0x800,0xC00,0x000 (wrap).
REQ-039 Single sample at cycle t -> ISS_I t+1, slc_in=in at t+5, i_out capture t+7, q_out t+8, out_valid t+9 (defaults).
REQ-040 in_valid at t, t+1 -> second dropped, overrun=1 at t+2; ovr_clr -> overrun=0 next cycle.
REQ-041 in_valid every 2 cycles for 16 samples -> 16 out_valid, no overrun, I/Q order preserved.
REQ-042 phs_rst with freq=0x10000000 mid-stream -> next accepted sample slc_phs=0x000, following 0x100.
REQ-043 reset asserted between ISS_Q and out_valid -> no out_valid, all outputs 0, next sample phase 0.
